// File: rtl/mod_count_bcd_display.sv
// Display back-end for the mod-n counter. It converts the binary count to three BCD
// digits using a sequential double-dabble engine and scans a 3-digit active-low 7-seg display.

module bcd_seg_dec (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  // Segment order is {g,f,e,d,c,b,a}, active-low. Codes 10..15 show blank.
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (digit)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module mod_count_bcd_display #(
  parameter int N       = 8,
  parameter int MAX     = 210,
  parameter int REFRESH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] count,
  output logic         busy,
  output logic         bcd_valid,
  output logic [3:0]   bcd_hundreds,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones,
  output logic         range_err,
  output logic [2:0]   an,
  output logic [6:0]   seg
);
  localparam int SW = N + 12;
  localparam int IW = $clog2(N + 1);
  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [31:0] MAXU = MAX;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state, state_nx;
  logic [SW-1:0]  sr, sr_adj;
  logic [IW-1:0]  iter;
  logic [N-1:0]   last_count;
  logic           first;
  logic           start;

  assign start = (state == IDLE) && (first || (count != last_count));
  assign busy  = (state == SHIFT) || (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (iter == IW'(N - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // BCD nibbles are located above the binary field. Any nibble >= 5 is corrected before each shift.
  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < 3; d++)
      if (sr[N+4*d +: 4] >= 4'd5) sr_adj[N+4*d +: 4] = sr[N+4*d +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      first        <= 1'b1;
      last_count   <= '0;
      sr           <= '0;
      iter         <= '0;
      bcd_valid    <= 1'b0;
      bcd_hundreds <= 4'd0;
      bcd_tens     <= 4'd0;
      bcd_ones     <= 4'd0;
      range_err    <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr         <= {12'b0, count};
          last_count <= count;
          first      <= 1'b0;
          iter       <= '0;
        end
        SHIFT: begin
          sr   <= {sr_adj[SW-2:0], 1'b0};
          iter <= iter + 1'b1;
        end
        DONE: begin
          bcd_hundreds <= sr[N+8 +: 4];
          bcd_tens     <= sr[N+4 +: 4];
          bcd_ones     <= sr[N   +: 4];
          range_err    <= ({{(32-N){1'b0}}, last_count} >= MAXU);
          bcd_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Display scan
  logic [RW-1:0]      refresh_cnt;
  logic [1:0]         digit_sel;
  logic               rfr_tc;
  logic [2:0][3:0]    dig;
  logic [2:0]         blank;
  logic [2:0][6:0]    seg_dig;
  logic [2:0]         an_nx;
  logic [6:0]         seg_nx;

  assign rfr_tc = (refresh_cnt == RW'(REFRESH - 1));
  assign dig    = {bcd_hundreds, bcd_tens, bcd_ones};
  assign blank  = {bcd_hundreds == 4'd0, (bcd_hundreds == 4'd0) && (bcd_tens == 4'd0), 1'b0};

  for (genvar g = 0; g < 3; g++) begin : g_dec
    bcd_seg_dec u_dec (
      .digit (dig[g]),
      .blank (blank[g]),
      .seg   (seg_dig[g])
    );
  end

  always_comb begin
    an_nx  = 3'b111;
    seg_nx = 7'b1111111;
    case (digit_sel)
      2'd0: begin an_nx = 3'b110; seg_nx = seg_dig[0]; end
      2'd1: begin an_nx = 3'b101; seg_nx = seg_dig[1]; end
      2'd2: begin an_nx = 3'b011; seg_nx = seg_dig[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt <= '0;
      digit_sel   <= 2'd0;
      an          <= 3'b111;
      seg         <= 7'b1111111;
    end else begin
      an  <= an_nx;
      seg <= seg_nx;
      if (rfr_tc) begin
        refresh_cnt <= '0;
        digit_sel   <= (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mod_count_bcd_display.sv
// Scoreboard bench for mod_count_bcd_display. Expected digits are pushed when a count is
// driven and popped on each bcd_valid pulse.

module tb_mod_count_bcd_display;
  localparam int N       = 8;
  localparam int MAX     = 210;
  localparam int REFRESH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] count = '0;
  logic         busy, bcd_valid, range_err;
  logic [3:0]   bcd_hundreds, bcd_tens, bcd_ones;
  logic [2:0]   an;
  logic [6:0]   seg;

  int          n_vec = 0;
  int          n_err = 0;
  logic [12:0] sb[$];

  mod_count_bcd_display #(.N(N), .MAX(MAX), .REFRESH(REFRESH)) dut (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .busy         (busy),
    .bcd_valid    (bcd_valid),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_ones     (bcd_ones),
    .range_err    (range_err),
    .an           (an),
    .seg          (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] exp_of(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o, v >= MAX};
  endfunction

  always @(negedge clk) begin
    if (bcd_valid) begin
      if (sb.size() == 0) chk("sb_unexpected_valid", 32'd1, 32'd0);
      else chk("bcd", {19'd0, bcd_hundreds, bcd_tens, bcd_ones, range_err}, {19'd0, sb.pop_front()});
    end
  end

  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bcd_valid && k < 40);
    if (!bcd_valid) chk("valid_tmo", 32'd0, 32'd1);
  endtask

  task automatic show_digit(input string tag, input logic [2:0] a, input logic [6:0] s);
    int k, dw;
    k = 0;
    while (an == a && k < 40) begin @(negedge clk); k++; end
    while (an != a && k < 40) begin @(negedge clk); k++; end
    if (an != a) begin
      chk({tag, "_tmo"}, {29'd0, an}, {29'd0, a});
      return;
    end
    chk(tag, {25'd0, seg}, {25'd0, s});
    dw = 0;
    while (an == a && dw < 40) begin @(negedge clk); dw++; end
    chk({tag, "_dwell"}, dw, REFRESH);
  endtask

  localparam logic [24:0] RST_VEC = {1'b0, 1'b0, 12'h000, 1'b0, 3'b111, 7'h7f};

  initial begin
    int k, bc, vc;
    // reset with count 0
    repeat (3) @(negedge clk);
    chk("reset_state", {7'd0, busy, bcd_valid, bcd_hundreds, bcd_tens, bcd_ones, range_err, an, seg},
        {7'd0, RST_VEC});
    rst = 1'b1;
    sb.push_back(exp_of(0));
    wait_valid(k);
    chk("lat_first", k, N + 2);
    show_digit("z_ones", 3'b110, 7'b1000000);
    show_digit("z_tens", 3'b101, 7'b1111111);
    show_digit("z_hund", 3'b011, 7'b1111111);

    // 209 held
    count = 8'd209;
    sb.push_back(exp_of(209));
    wait_valid(k);
    chk("lat_209", k, N + 2);
    show_digit("d209_ones", 3'b110, 7'b0010000);
    show_digit("d209_tens", 3'b101, 7'b1000000);
    show_digit("d209_hund", 3'b011, 7'b0100100);

    // incrementing every cycle: captures every N+2 edges
    repeat (5) @(negedge clk);
    count = 8'd5;
    sb.push_back(exp_of(5));
    sb.push_back(exp_of(15));
    sb.push_back(exp_of(25));
    sb.push_back(exp_of(35));
    bc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i <= 10) bc += int'(busy);
      count = 8'(5 + i);
    end
    chk("busy_run", bc, N + 1);
    repeat (15) @(negedge clk);

    // range check
    count = 8'd210;
    sb.push_back(exp_of(210));
    wait_valid(k);
    count = 8'd45;
    sb.push_back(exp_of(45));
    wait_valid(k);
    show_digit("d45_hund", 3'b011, 7'b1111111);
    show_digit("d45_tens", 3'b101, 7'b0011001);
    show_digit("d45_ones", 3'b110, 7'b0010010);

    // reset mid-conversion
    repeat (3) @(negedge clk);
    count = 8'd123;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mid", {7'd0, busy, bcd_valid, bcd_hundreds, bcd_tens, bcd_ones, range_err, an, seg},
        {7'd0, RST_VEC});
    rst = 1'b1;
    sb.push_back(exp_of(123));
    wait_valid(k);
    chk("lat_123", k, N + 2);

    // stable input
    repeat (3) @(negedge clk);
    count = 8'd77;
    sb.push_back(exp_of(77));
    vc = 0;
    bc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vc += int'(bcd_valid);
      bc += int'(busy);
    end
    chk("stable_valids", vc, 1);
    chk("stable_busy", bc, N + 1);

    repeat (5) @(negedge clk);
    chk("sb_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mod_count_bcd_display.md
# mod_count_bcd_display

Display back-end for the mod-n up/down counters. Consumes the counter's binary `out` bus, converts each new value to three BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a 3-digit multiplexed active-low seven-segment display. It also flags counts outside the modulus. Sits directly downstream of the counter on the same clock.

## Interface

**Parameters**
- `N`, default 8: width of the `count` input. Must satisfy 2^N − 1 ≤ 999.
- `MAX`, default 210: counter modulus. Legal counts are 0..MAX−1.
- `REFRESH`, default 4: clock cycles each digit is lit. Must be ≥ 1. Large in silicon, small in simulation.

**Ports** (clock and reset first)
- `clk`, input, 1: the single clock. Rising-edge.
- `rst`, input, 1: reset, synchronous, active-low. Sampled on the `clk` rising edge.
- `count`, input, N: binary value from the counter's `out`.
- `busy`, output, 1: high while a conversion is in progress.
- `bcd_valid`, output, 1: one-cycle pulse when the BCD outputs update.
- `bcd_hundreds`, output, 4: hundreds digit of the last converted value.
- `bcd_tens`, output, 4: tens digit.
- `bcd_ones`, output, 4: ones digit.
- `range_err`, output, 1: high when the last converted value is ≥ MAX.
- `an`, output, 3: digit enables, active-low one-hot. Bit 0 = ones, bit 1 = tens, bit 2 = hundreds.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation

**Conversion FSM: IDLE → SHIFT → DONE → IDLE**
- **IDLE:** converts when `count` ≠ `last_count` or the post-reset `first` flag is set.
  - On that edge: load the shift register with {12'b0, count}, set `last_count` = `count`, clear `first`, set the iteration counter to 0, go to SHIFT.
- **SHIFT:** runs exactly N edges. Each edge:
  - add 3 to every BCD nibble that is ≥ 5;
  - then shift the whole register left by 1.
  - Go to DONE on the edge that completes iteration N.
- **DONE:** one edge.
  - Load `bcd_hundreds`/`bcd_tens`/`bcd_ones`.
  - Set `range_err` = (`last_count` ≥ MAX).
  - Assert `bcd_valid` for the following cycle only.
  - Go to IDLE.
- `busy` is high in SHIFT and DONE.
- Changes on `count` during SHIFT/DONE are ignored. The value present at the next IDLE edge is converted, and intermediate values are dropped.
- Out-of-range values are still converted. The maximum is 255, which fits in 3 digits. `range_err` holds until the next in-range conversion completes.

**Display multiplexer** (runs continuously, independent of the FSM)
- `refresh_cnt` counts 0..REFRESH−1. On its terminal count, `digit_sel` advances 0 → 1 → 2 → 0.
- `an` and `seg` are registered every cycle from the current `digit_sel` and BCD registers.
- Digit select to `an`: digit 0 → 3'b110, digit 1 → 3'b101, digit 2 → 3'b011.
- Leading-zero blanking:
  - hundreds is blank if it is 0;
  - tens is blank if hundreds and tens are both 0;
  - ones is never blank.
  - A blank digit drives `seg` = 7'b1111111 with its `an` still asserted.
- Segment codes:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Codes 10–15 cannot occur and decode to blank.

## Timing

- **Reset values** (rst = 0 at an edge):
  - state = IDLE, `first` = 1, `last_count` = 0;
  - `busy` = 0, `bcd_valid` = 0, all BCD digits = 0, `range_err` = 0;
  - `refresh_cnt` = 0, `digit_sel` = 0;
  - `an` = 3'b111, `seg` = 7'b1111111.
- **Latency:** if edge E0 samples a new count in IDLE, then:
  - SHIFT occupies E1..EN;
  - DONE updates the outputs at edge E(N+1);
  - `bcd_valid` is high during the cycle after E(N+1).
  - For N = 8 that is 9 edges after E0. The next possible capture is at E(N+2).
- **Reset mid-conversion:** the conversion is abandoned and every output takes its reset value. After release, the held count is converted because `first` is set.
- **Display lag:** `an`/`seg` lag `digit_sel` by one cycle. New BCD values appear on the display within one cycle of `bcd_valid`.
- **Simultaneous terminal refresh and DONE:** the registered `seg` uses the pre-update BCD for that one cycle. This is not an error.

## Test plan

1. **Reset, count = 0 held.** Release `rst`.
   - 10 edges later: digits 0/0/0, a single one-cycle `bcd_valid`, `range_err` = 0.
   - When `an` = 110, `seg` = 1000000. Tens and hundreds show 1111111.
2. **count = 209 held.**
   - Digits 2/0/9 after N+1 edges past capture.
   - `an` cycles 110 → 101 → 011 every REFRESH cycles, with `seg` 0010000 → 1000000 → 0100100.
3. **Counter incrementing every cycle from 5.**
   - `busy` stays high across SHIFT/DONE and intermediate values are skipped.
   - Each conversion equals the count sampled at its IDLE edge, e.g. 5, then 15.
4. **Range check.**
   - count = 210: `range_err` = 1, digits 2/1/0.
   - Then count = 45: `range_err` = 0, digits 0/4/5, hundreds blanked.
5. **Reset mid-conversion.** Drive `rst` = 0 for one edge at iteration 4 of SHIFT.
   - All outputs take their reset values and `busy` = 0.
   - After release, the held count (e.g. 123) converts to 1/2/3.
6. **Stable input.** count held at 77 for 50 cycles.
   - Exactly one `bcd_valid` pulse and no further `busy`.
